// File: rtl/craft_sbox_layer_serial_pkg.sv
// craft_sbox_layer_serial_pkg: shared constants and FSM encoding for the serial CRAFT S-box layer
package craft_sbox_layer_serial_pkg;
  localparam int NB_DEFAULT = 16;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/craft_sbox.sv
// craft_sbox: combinational 4-bit CRAFT S-box
module craft_sbox (
  input  logic [3:0] x,
  output logic [3:0] y
);
  // table lookup, the only copy of the CRAFT S-box
  always_comb begin
    case (x)
      4'h0: y = 4'hC;
      4'h1: y = 4'hA;
      4'h2: y = 4'hD;
      4'h3: y = 4'h3;
      4'h4: y = 4'hE;
      4'h5: y = 4'hB;
      4'h6: y = 4'hF;
      4'h7: y = 4'h7;
      4'h8: y = 4'h8;
      4'h9: y = 4'h9;
      4'hA: y = 4'h1;
      4'hB: y = 4'h5;
      4'hC: y = 4'h0;
      4'hD: y = 4'h2;
      4'hE: y = 4'h4;
      default: y = 4'h6;
    endcase
  end
endmodule

// File: rtl/craft_sbox_layer_serial.sv
// craft_sbox_layer_serial: SubCells over a 4*NB-bit state, one nibble per enabled cycle
module craft_sbox_layer_serial
  import craft_sbox_layer_serial_pkg::*;
#(
  parameter int NB = NB_DEFAULT
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            CE,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4*NB-1:0] din,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4*NB-1:0] dout,
  output logic            busy
);
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;
  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [4*NB-1:0] dat_q, dat_d;
  logic [3:0]      sb_y;
  logic            last;
  craft_sbox u_sbox (.x(dat_q[3:0]), .y(sb_y));
  assign last      = cnt_q == CW'(NB - 1);
  assign in_ready  = (state_q == IDLE) && CE;
  assign out_valid = state_q == DONE;
  assign busy      = state_q != IDLE;
  assign dout      = dat_q;
  // next state: everything holds unless CE; RUN rotates right, substituted low nibble enters at top
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dat_d   = dat_q;
    case (state_q)
      IDLE: if (CE && in_valid) begin
        state_d = RUN;
        cnt_d   = '0;
        dat_d   = din;
      end
      RUN: if (CE) begin
        dat_d   = (4*NB)'({sb_y, dat_q} >> 4);
        cnt_d   = last ? '0 : cnt_q + 1'b1;
        state_d = last ? DONE : RUN;
      end
      DONE: if (CE && out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // state registers with asynchronous active-low reset
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dat_q   <= dat_d;
    end
  end
endmodule

// File: tb/tb_craft_sbox_layer_serial.sv
// tb_craft_sbox_layer_serial: directed self-checking bench for the serial S-box layer
module tb_craft_sbox_layer_serial;
  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        CE = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] din = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] dout;
  logic        busy;
  int checks = 0;
  int failures = 0;

  craft_sbox_layer_serial #(.NB(16)) dut (
    .CLK(CLK), .RST(RST), .CE(CE), .in_valid(in_valid), .in_ready(in_ready),
    .din(din), .out_valid(out_valid), .out_ready(out_ready), .dout(dout), .busy(busy)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_block(input logic [63:0] d, input logic [63:0] e, input bit alt,
                          input int exp_edges, input string tag);
    int n;
    logic [63:0] prev;
    n = 0;
    CE = 1'b1;
    din = d;
    in_valid = 1'b1;
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    chk({tag, "_busy"}, 64'(busy), 64'd1);
    chk({tag, "_inrdy_run"}, 64'(in_ready), 64'd0);
    while (!out_valid && n < 200) begin
      CE = alt ? ~CE : 1'b1;
      prev = dout;
      tick();
      n++;
      if (alt && !CE) chk({tag, "_ce0_hold"}, dout, prev);
    end
    CE = 1'b1;
    chk({tag, "_lat"}, 64'(n), 64'(exp_edges));
    chk({tag, "_dout"}, dout, e);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_idle"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    logic [63:0] vin [3];
    logic [63:0] vexp [3];
    logic [63:0] hold;
    int acc, res, last_res;
    logic pbusy;
    #1;
    chk("rst_ov", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_dout", dout, 64'd0);
    tick();
    @(negedge CLK);
    RST = 1'b1;
    CE = 1'b0;
    #1;
    chk("inrdy_ce0", 64'(in_ready), 64'd0);
    CE = 1'b1;
    #1;
    chk("inrdy_ce1", 64'(in_ready), 64'd1);

    do_block(64'h0000000000000000, 64'hCCCCCCCCCCCCCCCC, 1'b0, 16, "zero");
    do_block(64'h0123456789ABCDEF, 64'hCAD3EBF789150246, 1'b0, 16, "ramp");
    do_block(64'hCAD3EBF789150246, 64'h0123456789ABCDEF, 1'b0, 16, "invol");
    do_block(64'h0123456789ABCDEF, 64'hCAD3EBF789150246, 1'b1, 32, "cealt");

    // output backpressure in DONE with in_valid asserted
    CE = 1'b1;
    din = 64'h1111111111111111;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (16) tick();
    chk("bp_ov0", 64'(out_valid), 64'd1);
    hold = dout;
    chk("bp_dout0", hold, 64'hAAAAAAAAAAAAAAAA);
    din = 64'h2222222222222222;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_ov", 64'(out_valid), 64'd1);
      chk("bp_dout", dout, hold);
      chk("bp_inrdy", 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_release_ov", 64'(out_valid), 64'd0);
    chk("bp_release_busy", 64'(busy), 64'd0);

    // reset in the middle of RUN
    din = 64'hFFFFFFFFFFFFFFFF;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (7) tick();
    #2;
    RST = 1'b0;
    #1;
    chk("mid_rst_ov", 64'(out_valid), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_dout", dout, 64'd0);
    @(negedge CLK);
    RST = 1'b1;
    do_block(64'hFFFFFFFFFFFFFFFF, 64'h6666666666666666, 1'b0, 16, "post_rst");

    // back-to-back with in_valid held high
    vin[0] = 64'h0123456789ABCDEF; vexp[0] = 64'hCAD3EBF789150246;
    vin[1] = 64'hCAD3EBF789150246; vexp[1] = 64'h0123456789ABCDEF;
    vin[2] = 64'hFFFFFFFFFFFFFFFF; vexp[2] = 64'h6666666666666666;
    acc = 0;
    res = 0;
    last_res = -1;
    pbusy = 1'b0;
    CE = 1'b1;
    out_ready = 1'b1;
    din = vin[0];
    in_valid = 1'b1;
    for (int c = 0; c < 80 && res < 3; c++) begin
      tick();
      if (busy && !pbusy) begin
        acc++;
        din = (acc < 3) ? vin[acc] : 64'h0;
        if (acc >= 3) in_valid = 1'b0;
      end
      pbusy = busy;
      if (out_valid) begin
        chk("b2b_dout", dout, vexp[res]);
        if (last_res >= 0) chk("b2b_period", 64'(c - last_res), 64'd18);
        last_res = c;
        res++;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("b2b_count", 64'(res), 64'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/craft_sbox_layer_serial.md
CRAFT_SBOX_LAYER_SERIAL -- requirements
Module: craft_sbox_layer_serial

Interface
REQ-001 The block SHALL have parameter NB, default 16, giving the number of 4-bit nibbles per state (state width 4*NB).
REQ-002 The block SHALL have port CLK  input  1  system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port RST  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have port CE  input  1  clock enable; no state changes when CE=0.
REQ-005 The block SHALL have port in_valid  input  1  din carries a state to substitute.
REQ-006 The block SHALL have port in_ready  output  1  block accepts din this cycle.
REQ-007 The block SHALL have port din  input  4*NB  state in; nibble i = din[4i+3:4i].
REQ-008 The block SHALL have port out_valid  output  1  dout holds a completed result.
REQ-009 The block SHALL have port out_ready  input  1  consumer takes dout this cycle.
REQ-010 The block SHALL have port dout  output  4*NB  state after SubCells applied to every nibble.
REQ-011 The block SHALL have port busy  output  1  high in RUN and DONE.

Function
REQ-012 The block SHALL apply the CRAFT S-box to each nibble: 0..F -> C,A,D,3,E,B,F,7,8,9,1,5,0,2,4,6.
REQ-013 The block SHALL use one S-box instance, processing one nibble per enabled cycle, nibble 0 first.
REQ-014 The datapath SHALL be a 4*NB-bit register rotated right by 4 each RUN step, with the S-box output of the low nibble written into the top nibble.
REQ-015 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-016 IDLE: in_ready = CE; on in_valid=1 and CE=1, load din, clear the nibble counter, go to RUN.
REQ-017 RUN: on each edge with CE=1, substitute one nibble and increment the counter; on the edge processing nibble NB-1, go to DONE.
REQ-018 DONE: out_valid=1 and dout = register; on out_ready=1 and CE=1, go to IDLE.
REQ-019 in_ready SHALL be 0 in RUN and DONE; new input is not accepted in the same cycle as output completes.
REQ-020 Latency: acceptance on edge T, with CE held high, SHALL give out_valid high after edge T+NB; a block takes NB+2 enabled cycles.
REQ-021 With CE=0 in any state, the register, counter and FSM SHALL hold; out_valid and dout SHALL stay stable in DONE.
REQ-022 dout SHALL remain constant while out_valid=1 and out_ready=0, for any number of cycles.
REQ-023 dout outside DONE SHALL be the internal register value, is don't-care to consumers, and SHALL NOT be X after reset.
REQ-024 The nibble counter SHALL be clog2(NB) bits wide and SHALL never exceed NB-1.
REQ-025 in_valid in RUN or DONE SHALL be ignored, with no effect on state.

Reset
REQ-026 RST=0 SHALL immediately force IDLE, counter=0, register=0, out_valid=0, busy=0, independent of CLK and CE.
REQ-027 Reset during RUN or DONE SHALL discard the block in flight; the first block accepted after release SHALL produce a correct result.
REQ-028 in_ready SHALL equal CE from reset release onward.

Structure
REQ-029 The S-box SHALL be the existing combinational craft_sbox sub-module, instantiated once; its table SHALL NOT be duplicated.
REQ-030 The FSM state encoding and the NB default SHALL live in the shared CRAFT package/header as constants; the S-box table stays in craft_sbox.

Verification
REQ-031 din=0x0000000000000000, CE=1, out_ready=1 -> out_valid 16 edges after acceptance, dout=0xCCCCCCCCCCCCCCCC.
REQ-032 din=0x0123456789ABCDEF -> dout=0xCAD3EBF789150246; feeding that back -> dout=0x0123456789ABCDEF (involution).
REQ-033 CE alternating 1/0 from acceptance onward -> same dout as REQ-032, out_valid after 32 cycles, no state change on CE=0 cycles.
REQ-034 out_ready held 0 for 5 cycles in DONE -> out_valid=1 and dout stable throughout, in_ready=0 and in_valid ignored; out_ready=1 -> IDLE next edge.
REQ-035 RST pulsed low at nibble 7 of RUN -> out_valid=0, busy=0 immediately; next block 0xFFFFFFFFFFFFFFFF -> dout=0x6666666666666666.
REQ-036 Back-to-back blocks with in_valid held high -> each accepted only in IDLE, one result per 18 cycles, results in order.
